// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port SRAM between the fetch port and the data port
// Data side wins by default; a D-grant streak counter guarantees the fetch port eventually wins.
module mem_port_arbiter #(
   parameter int AW           = 10,
   parameter int BW           = 32,
   parameter int MAX_D_STREAK = 4
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          I_REQ,
   input  logic [29:0]   I_ADDR,
   output logic          I_GNT,
   output logic          I_RVALID,
   output logic [BW-1:0] I_RDATA,
   input  logic          D_REQ,
   input  logic          D_RW,
   input  logic [29:0]   D_ADDR,
   input  logic [BW-1:0] D_WDATA,
   output logic          D_GNT,
   output logic          D_RVALID,
   output logic [BW-1:0] D_RDATA,
   output logic          MEM_CSN,
   output logic          MEM_WEN,
   output logic [AW-1:0] MEM_A,
   output logic [BW-1:0] MEM_DI,
   input  logic [BW-1:0] MEM_DOUT,
   output logic          ERR_OOR
);

   localparam logic [3:0] MAX_STREAK = 4'(MAX_D_STREAK);

   typedef enum logic [2:0] {
      OWN_NONE  = 3'd0,
      OWN_I_RD  = 3'd1,
      OWN_D_RD  = 3'd2,
      OWN_OOR_I = 3'd3,
      OWN_OOR_D = 3'd4
   } owner_t;

   owner_t        r_ret_owner;
   owner_t        w_ret_next;
   logic [3:0]    r_d_streak;
   logic          r_err_oor;
   logic [BW-1:0] r_i_hold;
   logic [BW-1:0] r_d_hold;
   logic          w_i_inr;
   logic          w_d_inr;
   logic          w_i_gnt;
   logic          w_d_gnt;

   assign w_i_inr = (I_ADDR[29:AW] == '0);
   assign w_d_inr = (D_ADDR[29:AW] == '0);

   always_comb begin
      w_i_gnt = 1'b0;
      w_d_gnt = 1'b0;
      if (!RST) begin
         if (I_REQ && D_REQ) begin
            if (r_d_streak < MAX_STREAK) w_d_gnt = 1'b1;
            else                         w_i_gnt = 1'b1;
         end else begin
            w_i_gnt = I_REQ;
            w_d_gnt = D_REQ;
         end
      end
   end

   assign I_GNT   = w_i_gnt;
   assign D_GNT   = w_d_gnt;
   assign ERR_OOR = r_err_oor;

   always_ff @(posedge CLK) begin
      if (RST)                     r_d_streak <= 4'd0;
      else if (!I_REQ || w_i_gnt)  r_d_streak <= 4'd0;
      else if (w_d_gnt && r_d_streak < MAX_STREAK)
                                   r_d_streak <= r_d_streak + 4'd1;
   end

   // Out-of-range grants never reach the SRAM; the address/data buses stay at zero.
   always_comb begin
      MEM_CSN = 1'b1;
      MEM_WEN = 1'b1;
      MEM_A   = '0;
      MEM_DI  = '0;
      if (w_i_gnt && w_i_inr) begin
         MEM_CSN = 1'b0;
         MEM_A   = I_ADDR[AW-1:0];
      end else if (w_d_gnt && w_d_inr) begin
         MEM_CSN = 1'b0;
         MEM_A   = D_ADDR[AW-1:0];
         if (D_RW) begin
            MEM_WEN = 1'b0;
            MEM_DI  = D_WDATA;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) r_err_oor <= 1'b0;
      else if ((w_i_gnt && !w_i_inr) || (w_d_gnt && !w_d_inr)) r_err_oor <= 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (RST) r_ret_owner <= OWN_NONE;
      else     r_ret_owner <= w_ret_next;
   end

   always_comb begin
      w_ret_next = OWN_NONE;
      if (w_i_gnt)
         w_ret_next = w_i_inr ? OWN_I_RD : OWN_OOR_I;
      else if (w_d_gnt && !D_RW)
         w_ret_next = w_d_inr ? OWN_D_RD : OWN_OOR_D;
   end

   // SRAM data is bypassed in the return cycle and latched into the hold register at its end.
   always_comb begin
      I_RVALID = !RST && (r_ret_owner == OWN_I_RD || r_ret_owner == OWN_OOR_I);
      D_RVALID = !RST && (r_ret_owner == OWN_D_RD || r_ret_owner == OWN_OOR_D);
      I_RDATA  = r_i_hold;
      D_RDATA  = r_d_hold;
      if (I_RVALID) I_RDATA = (r_ret_owner == OWN_I_RD) ? MEM_DOUT : '0;
      if (D_RVALID) D_RDATA = (r_ret_owner == OWN_D_RD) ? MEM_DOUT : '0;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_i_hold <= '0;
         r_d_hold <= '0;
      end else begin
         if (I_RVALID) r_i_hold <= I_RDATA;
         if (D_RVALID) r_d_hold <= D_RDATA;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed bench with SRAM model and read-return scoreboard
module tb_mem_port_arbiter;

   logic        CLK;
   logic        RST;
   logic        I_REQ;
   logic [29:0] I_ADDR;
   logic        I_GNT;
   logic        I_RVALID;
   logic [31:0] I_RDATA;
   logic        D_REQ;
   logic        D_RW;
   logic [29:0] D_ADDR;
   logic [31:0] D_WDATA;
   logic        D_GNT;
   logic        D_RVALID;
   logic [31:0] D_RDATA;
   logic        MEM_CSN;
   logic        MEM_WEN;
   logic [9:0]  MEM_A;
   logic [31:0] MEM_DI;
   logic [31:0] MEM_DOUT;
   logic        ERR_OOR;

   mem_port_arbiter #(.AW(10), .BW(32), .MAX_D_STREAK(4)) dut (
      .CLK(CLK), .RST(RST),
      .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_GNT(I_GNT), .I_RVALID(I_RVALID), .I_RDATA(I_RDATA),
      .D_REQ(D_REQ), .D_RW(D_RW), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA), .D_GNT(D_GNT),
      .D_RVALID(D_RVALID), .D_RDATA(D_RDATA),
      .MEM_CSN(MEM_CSN), .MEM_WEN(MEM_WEN), .MEM_A(MEM_A), .MEM_DI(MEM_DI),
      .MEM_DOUT(MEM_DOUT), .ERR_OOR(ERR_OOR)
   );

   int          total = 0;
   int          bad   = 0;
   logic [31:0] sram    [1024];
   logic [31:0] ref_mem [1024];
   logic [31:0] iq[$];
   logic [31:0] dq[$];

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(posedge CLK) begin
      if (!MEM_CSN) begin
         if (!MEM_WEN) sram[MEM_A] <= MEM_DI;
         else          MEM_DOUT    <= sram[MEM_A];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_read(input logic [29:0] a);
      return (a[29:10] != '0) ? 32'h0 : ref_mem[a[9:0]];
   endfunction

   // Every granted read must return exactly one cycle later, in grant order.
   always @(negedge CLK) begin
      logic [31:0] e;
      if (RST) begin
         chk("rst_gnt", {30'h0, I_GNT, D_GNT}, 32'h0);
         chk("rst_rvalid", {30'h0, I_RVALID, D_RVALID}, 32'h0);
         chk("rst_csn_wen", {30'h0, MEM_CSN, MEM_WEN}, 32'h3);
         iq.delete();
         dq.delete();
      end else begin
         chk("i_rvalid", I_RVALID, iq.size() != 0);
         if (iq.size() != 0) begin
            e = iq.pop_front();
            if (I_RVALID) chk("i_rdata", I_RDATA, e);
         end
         chk("d_rvalid", D_RVALID, dq.size() != 0);
         if (dq.size() != 0) begin
            e = dq.pop_front();
            if (D_RVALID) chk("d_rdata", D_RDATA, e);
         end
         chk("gnt_excl", I_GNT & D_GNT, 32'h0);
         if (I_GNT) iq.push_back(exp_read(I_ADDR));
         if (D_GNT) begin
            if (!D_RW) dq.push_back(exp_read(D_ADDR));
            else if (D_ADDR[29:10] == '0) ref_mem[D_ADDR[9:0]] = D_WDATA;
         end
      end
   end

   initial begin
      for (int i = 0; i < 1024; i++) begin
         sram[i]    = 32'hC0DE0000 | 32'(i);
         ref_mem[i] = 32'hC0DE0000 | 32'(i);
      end
      sram[3] = 32'h33; ref_mem[3] = 32'h33;
      sram[4] = 32'h44; ref_mem[4] = 32'h44;
      MEM_DOUT = '0;
      RST = 1'b1; I_REQ = 0; I_ADDR = '0; D_REQ = 0; D_RW = 0; D_ADDR = '0; D_WDATA = '0;

      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;
      @(negedge CLK);
      chk("idle_csn", MEM_CSN, 1'b1);
      chk("idle_wen", MEM_WEN, 1'b1);
      chk("idle_gnt", {I_GNT, D_GNT}, 32'h0);
      chk("idle_i_rdata", I_RDATA, 32'h0);
      chk("idle_d_rdata", D_RDATA, 32'h0);
      chk("idle_err", ERR_OOR, 1'b0);

      // Write then fetch the same word.
      @(posedge CLK); #1;
      D_REQ = 1; D_RW = 1; D_ADDR = 30'h10; D_WDATA = 32'hDEADBEEF;
      @(negedge CLK);
      chk("wr_dgnt", D_GNT, 1'b1);
      chk("wr_csn", MEM_CSN, 1'b0);
      chk("wr_wen", MEM_WEN, 1'b0);
      chk("wr_a", MEM_A, 32'h10);
      chk("wr_di", MEM_DI, 32'hDEADBEEF);
      @(posedge CLK); #1;
      D_REQ = 0; D_RW = 0; I_REQ = 1; I_ADDR = 30'h10;
      @(negedge CLK);
      chk("rd_ignt", I_GNT, 1'b1);
      chk("rd_wen", MEM_WEN, 1'b1);
      @(posedge CLK); #1;
      I_REQ = 0;
      @(negedge CLK);
      chk("rd_ivalid", I_RVALID, 1'b1);
      chk("rd_idata", I_RDATA, 32'hDEADBEEF);
      @(posedge CLK); #1;
      @(negedge CLK);
      chk("rd_ihold", I_RDATA, 32'hDEADBEEF);

      // Starvation protection.
      @(posedge CLK); #1;
      I_REQ = 1; I_ADDR = 30'h6; D_REQ = 1; D_RW = 0; D_ADDR = 30'h5;
      for (int k = 0; k < 10; k++) begin
         @(negedge CLK);
         chk("starve_d", D_GNT, (k % 5) != 4);
         chk("starve_i", I_GNT, (k % 5) == 4);
         @(posedge CLK); #1;
      end
      I_REQ = 0; D_REQ = 0;
      @(negedge CLK);

      // Back-to-back alternating reads.
      @(posedge CLK); #1;
      D_REQ = 1; D_ADDR = 30'h3;
      @(negedge CLK);
      chk("b2b_dgnt0", D_GNT, 1'b1);
      @(posedge CLK); #1;
      D_REQ = 0; I_REQ = 1; I_ADDR = 30'h4;
      @(negedge CLK);
      chk("b2b_ignt1", I_GNT, 1'b1);
      chk("b2b_dv1", D_RVALID, 1'b1);
      chk("b2b_dd1", D_RDATA, 32'h33);
      @(posedge CLK); #1;
      I_REQ = 0; D_REQ = 1;
      @(negedge CLK);
      chk("b2b_iv2", I_RVALID, 1'b1);
      chk("b2b_id2", I_RDATA, 32'h44);
      @(posedge CLK); #1;
      D_REQ = 0; I_REQ = 1;
      @(negedge CLK);
      chk("b2b_dv3", D_RVALID, 1'b1);
      chk("b2b_dd3", D_RDATA, 32'h33);
      @(posedge CLK); #1;
      I_REQ = 0;
      @(negedge CLK);
      chk("b2b_iv4", I_RVALID, 1'b1);
      chk("b2b_id4", I_RDATA, 32'h44);
      repeat (2) begin
         @(posedge CLK); #1;
         @(negedge CLK);
         chk("b2b_dhold", D_RDATA, 32'h33);
         chk("b2b_ihold", I_RDATA, 32'h44);
      end

      // Out-of-range data read.
      @(posedge CLK); #1;
      D_REQ = 1; D_RW = 0; D_ADDR = 30'h400;
      @(negedge CLK);
      chk("oor_dgnt", D_GNT, 1'b1);
      chk("oor_csn", MEM_CSN, 1'b1);
      chk("oor_err0", ERR_OOR, 1'b0);
      @(posedge CLK); #1;
      D_REQ = 0;
      @(negedge CLK);
      chk("oor_dv", D_RVALID, 1'b1);
      chk("oor_dd", D_RDATA, 32'h0);
      chk("oor_err1", ERR_OOR, 1'b1);
      @(posedge CLK); #1;
      D_REQ = 1; D_RW = 1; D_ADDR = 30'h405; D_WDATA = 32'h12345678;
      @(negedge CLK);
      chk("oorw_csn", MEM_CSN, 1'b1);
      chk("oorw_wen", MEM_WEN, 1'b1);
      @(posedge CLK); #1;
      D_REQ = 0; D_RW = 0;
      @(negedge CLK);
      chk("oor_sticky", ERR_OOR, 1'b1);
      chk("oor_dhold", D_RDATA, 32'h0);

      // Reset while a fetch return is pending.
      @(posedge CLK); #1;
      I_REQ = 1; I_ADDR = 30'h4;
      @(negedge CLK);
      chk("mrst_ignt", I_GNT, 1'b1);
      @(posedge CLK); #1;
      I_REQ = 0; RST = 1;
      @(negedge CLK);
      chk("mrst_iv_in", I_RVALID, 1'b0);
      @(posedge CLK); #1;
      RST = 0;
      @(negedge CLK);
      chk("mrst_iv", I_RVALID, 1'b0);
      chk("mrst_id", I_RDATA, 32'h0);
      chk("mrst_dd", D_RDATA, 32'h0);
      chk("mrst_err", ERR_OOR, 1'b0);

      // Streak counter cleared by reset: build up 3 D grants, reset, expect a full 4 again.
      @(posedge CLK); #1;
      I_REQ = 1; I_ADDR = 30'h7; D_REQ = 1; D_ADDR = 30'h8;
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK);
         chk("pre_d", D_GNT, 1'b1);
         @(posedge CLK); #1;
      end
      RST = 1;
      @(negedge CLK);
      @(posedge CLK); #1;
      RST = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge CLK);
         chk("post_d", D_GNT, k != 4);
         chk("post_i", I_GNT, k == 4);
         @(posedge CLK); #1;
      end
      I_REQ = 0; D_REQ = 0;
      @(negedge CLK);
      @(posedge CLK); #1;
      chk("iq_empty", iq.size(), 32'h0);
      chk("dq_empty", dq.size(), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
